alu_console: RTL
================

# alu_console

Parametrised front-panel controller for the ALU: takes operands and opcode from board switches through a debounced, edge-detected continue key. Captures them into registers and instantiates `alu` (fixed 8-bit opcode, 5-bit flags). It shows the state and operand/result on a bank of 7-segment digits through `hex2seg`. Compared with the single-press, level-sensitive demo controller, it adds:
- one advance per key press;
- operand widths wider than the switch bank, entered chunk-wise;
- registered results and flags;
- an accumulator-chaining mode.

## Interface
- `DATA_W`, 16: operand/result width. Must be a multiple of 4 and of `CHUNK_W`.
- `SW_W`, 10: number of switches.
- `CHUNK_W`, 8: switch bits captured per press. Requires `CHUNK_W <= SW_W-1`.
- `DEBOUNCE_CYCLES`, 500000: clocks the key must be stable before it is accepted.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset (KEY0).
- `cont` in 1: continue key (KEY3), active-low, asynchronous to `clk`.
- `sw` in `SW_W`: switches. `sw[SW_W-1]` is the chain/mode switch. `sw[CHUNK_W-1:0]` is the data chunk.
- `hex_out` out `7*(DATA_W/4+1)`: segment bus from `hex2seg`, 7 bits per digit.
  - Digit 0 (bits [6:0]) is the least-significant nibble.
  - The top digit is the state letter.
- `flag_leds` out 5: registered ALU flags.

## Operation
Derived constant: `NCHUNK = DATA_W/CHUNK_W`.

**Key conditioning**
- `cont` passes through a 2-flop synchroniser, then a stability counter.
- The debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal synchronised samples.
- A 1-to-0 transition of the debounced level produces a one-cycle `press` pulse.
- A key release never produces a pulse.

**State machine** (all transitions are taken on the clock edge where `press`=1, unless stated otherwise)
- **S_RESET**: held while `reset`=0. Moves to S_A unconditionally on the first clock with `reset`=1.
- **S_A**
  - Each press writes `sw[CHUNK_W-1:0]` into chunk `idx` of `A_r`, MSB chunk first, with `idx` counting `NCHUNK-1` down to 0.
  - The press that writes chunk 0 moves to S_B and reloads `idx` to `NCHUNK-1`.
- **S_B**: same as S_A, writing `B_r`. The final chunk moves to S_OP.
- **S_OP**
  - A press writes `sw[7:0]` into `op_r`.
  - The same edge latches the ALU output into `C_r` and its flags into `flags_r`. The ALU sees `A_r`, `B_r` and the live `sw[7:0]` as its opcode.
  - Moves to S_C.
- **S_C**, on a press:
  - If `sw[SW_W-1]`=1 (chain): `A_r` ← `C_r`, then go to S_B.
  - If `sw[SW_W-1]`=0: go to S_A. `A_r`, `B_r` and `op_r` keep their values until they are overwritten.

**Display**
- State letter: S_RESET '0', S_A 'A', S_B 'b', S_OP '0', S_C 'C'.
- Value digits:
  - S_A and S_B show the target operand, with chunk `idx` replaced by the live switches (preview).
  - S_OP shows `op_r` zero-extended to `DATA_W`, with its low 8 bits live.
  - S_C shows `C_r`.
  - S_RESET shows 0.
- `flag_leds` = `flags_r` in S_C, and 0 in every other state.

**Reset values**
- State S_RESET.
- `A_r`, `B_r`, `C_r`, `op_r` and `flags_r` are all 0.
- `idx` = `NCHUNK-1`.
- Debounced level = released (1). Counter = 0.
- All digits display 0. `flag_leds` = 0.

## Timing
- Press latency:
  - `press` asserts `DEBOUNCE_CYCLES`+2 clocks after `cont` goes low and stays low.
  - State and registers update on the edge where `press`=1.
  - The display reflects the new state one `hex2seg` combinational delay later, with no added register stage.
- A held key produces exactly one press. Bounce shorter than `DEBOUNCE_CYCLES` produces none.
- Reset mid-entry: the partial operand is discarded, all registers clear, and the counter clears. A key held through reset yields no press after reset, because the debounced level must first return to 1.
- `press` in the same cycle as `reset`=0: reset wins.
- `NCHUNK`=1: every press completes its operand.
- The chunk index wraps only by the reload on operand completion and never underflows.
- ALU arithmetic and flag semantics are those of `alu`. Result width is `DATA_W`, and carry-out is reported only via flags.

## Structure
- Package `alu_console_pkg` holds:
  - the state enum;
  - the state-letter nibble constants;
  - the `NCHUNK` computation;
  - the chain-switch index.
- Sub-module `button_debounce`, parametrised by `DEBOUNCE_CYCLES`. It contains the synchroniser, the counter, the debounced level and the falling-edge pulse, and uses the same clock and reset.
- The top level instantiates `alu`, `button_debounce` and `DATA_W/4+1` copies of `hex2seg` in a generate loop.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `DATA_W`=16, `CHUNK_W`=8.
- **Debounce**: `cont` glitches low for 3 clocks → no press. `cont` low for 10 clocks → exactly one press, at clock 6.
- **Chunked entry**: press sw=0x12, then 0x34 → `A_r`=0x1234, state S_B. Display shows 'b' after the second press.
- **Full op**: A=0x1234, B=0x0001, then press the add opcode → S_C, `C_r`=0x1235, `flag_leds` show zero/carry clear. Flags read 0 in S_A.
- **Chain**: in S_C with `C_r`=0x1235, press with `sw[9]`=1 → `A_r`=0x1235, state S_B. Enter B=0x0001 and the add opcode → `C_r`=0x1236.
- **Reset mid-entry**: after one chunk of A, assert `reset`=0 for 1 clock while holding `cont` low → all registers 0, state S_A, no press until the key is released and pressed again.
- **Preview**: in S_A with `idx`=1 and sw=0xAB → display value 0xAB00, `A_r` unchanged at 0.

Source files
------------

// File: rtl/alu_console_pkg.sv
// Shared types and constants for the ALU front-panel console.
package alu_console_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_A,
    S_B,
    S_OP,
    S_C
  } state_t;

  // Nibble codes fed to hex2seg for the state-letter digit
  localparam logic [3:0] LET_RESET = 4'h0;
  localparam logic [3:0] LET_A     = 4'hA;
  localparam logic [3:0] LET_B     = 4'hB;
  localparam logic [3:0] LET_OP    = 4'h0;
  localparam logic [3:0] LET_C     = 4'hC;

  // Number of switch presses needed to enter one operand
  function automatic int calc_nchunk(input int data_w, input int chunk_w);
    return data_w / chunk_w;
  endfunction

  // The top switch selects accumulator chaining
  function automatic int chain_sw_idx(input int sw_w);
    return sw_w - 1;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: 8-bit opcode, flags = {parity, overflow, negative, carry, zero}.
module alu #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [7:0]   op,
  output logic [W-1:0] y,
  output logic [4:0]   flags
);

  logic [W:0] wide;
  logic       ovf;

  // Compute the result one bit wider so the carry/borrow falls out of the top bit
  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    case (op)
      8'h00: begin
        wide = {1'b0, a} + {1'b0, b};
        ovf  = (a[W-1] == b[W-1]) && (wide[W-1] != a[W-1]);
      end
      8'h01: begin
        wide = {1'b0, a} - {1'b0, b};
        ovf  = (a[W-1] != b[W-1]) && (wide[W-1] != a[W-1]);
      end
      8'h02:   wide = {1'b0, a & b};
      8'h03:   wide = {1'b0, a | b};
      8'h04:   wide = {1'b0, a ^ b};
      default: wide = '0;
    endcase
    y     = wide[W-1:0];
    flags = {^wide[W-1:0], ovf, wide[W-1], wide[W], (wide[W-1:0] == '0)};
  end

endmodule

// File: rtl/button_debounce.sv
// Synchronises an active-low key, debounces it and emits one pulse per press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             armed;
  logic [CNT_W-1:0] count;

  // Synchroniser resets low and 'armed' waits for a seen release, so a key held through reset never fires
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b1;
      armed <= 1'b0;
      count <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2) armed <= 1'b1;
      if (sync2 != level) begin
        if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          count <= '0;
          press <= armed & ~sync2;
        end else begin
          count <= count + CNT_W'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/hex2seg.sv
// Hex nibble to active-low 7-segment pattern, bit 0 = segment a.
module hex2seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Fixed glyph table; b and d are lower case so they differ from 8 and 0
  always_comb begin
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/alu_console.sv
// Front-panel ALU console: chunked operand entry, registered result, chaining and 7-seg display.
module alu_console
  import alu_console_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int SW_W            = 10,
  parameter int CHUNK_W         = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cont,
  input  logic [SW_W-1:0]            sw,
  output logic [7*(DATA_W/4+1)-1:0]  hex_out,
  output logic [4:0]                 flag_leds
);

  localparam int NCHUNK = calc_nchunk(DATA_W, CHUNK_W);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int NDIG   = DATA_W / 4;
  localparam int CHAIN  = chain_sw_idx(SW_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

  state_t             state, state_n;
  logic [DATA_W-1:0]  a_r, a_n, b_r, b_n, c_r, c_n;
  logic [7:0]         op_r, op_n;
  logic [4:0]         flags_r, flags_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               press;
  logic [DATA_W-1:0]  alu_y;
  logic [4:0]         alu_flags;
  logic [DATA_W-1:0]  a_prev, b_prev, disp_val;
  logic [3:0]         letter;
  logic               unused_bits;

  assign unused_bits = ^{op_r, sw};

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .reset (reset),
    .key_n (cont),
    .press (press)
  );

  alu #(.W(DATA_W)) u_alu (
    .a     (a_r),
    .b     (b_r),
    .op    (sw[7:0]),
    .y     (alu_y),
    .flags (alu_flags)
  );

  // Operands with the chunk under entry replaced by the live switches
  always_comb begin
    a_prev = a_r;
    b_prev = b_r;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IDX_W'(k)) begin
        a_prev[k*CHUNK_W +: CHUNK_W] = sw[CHUNK_W-1:0];
        b_prev[k*CHUNK_W +: CHUNK_W] = sw[CHUNK_W-1:0];
      end
    end
  end

  // Next-state and register updates, all advanced only by a debounced press
  always_comb begin
    state_n = state;
    a_n     = a_r;
    b_n     = b_r;
    c_n     = c_r;
    op_n    = op_r;
    flags_n = flags_r;
    idx_n   = idx;
    case (state)
      S_RESET: state_n = S_A;
      S_A: if (press) begin
        a_n = a_prev;
        if (idx == '0) begin
          idx_n   = IDX_TOP;
          state_n = S_B;
        end else begin
          idx_n = idx - IDX_W'(1);
        end
      end
      S_B: if (press) begin
        b_n = b_prev;
        if (idx == '0) begin
          idx_n   = IDX_TOP;
          state_n = S_OP;
        end else begin
          idx_n = idx - IDX_W'(1);
        end
      end
      S_OP: if (press) begin
        op_n    = sw[7:0];
        c_n     = alu_y;
        flags_n = alu_flags;
        state_n = S_C;
      end
      S_C: if (press) begin
        if (sw[CHAIN]) begin
          a_n     = c_r;
          state_n = S_B;
        end else begin
          state_n = S_A;
        end
      end
      default: state_n = S_RESET;
    endcase
  end

  // State and operand registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_RESET;
      a_r     <= '0;
      b_r     <= '0;
      c_r     <= '0;
      op_r    <= '0;
      flags_r <= '0;
      idx     <= IDX_TOP;
    end else begin
      state   <= state_n;
      a_r     <= a_n;
      b_r     <= b_n;
      c_r     <= c_n;
      op_r    <= op_n;
      flags_r <= flags_n;
      idx     <= idx_n;
    end
  end

  // Pick the state letter, value digits and flag LEDs for the current state
  always_comb begin
    letter    = LET_RESET;
    disp_val  = '0;
    flag_leds = '0;
    case (state)
      S_A:  begin letter = LET_A;  disp_val = a_prev; end
      S_B:  begin letter = LET_B;  disp_val = b_prev; end
      S_OP: begin letter = LET_OP; disp_val = DATA_W'(sw[7:0]); end
      S_C:  begin letter = LET_C;  disp_val = c_r; flag_leds = flags_r; end
      default: begin letter = LET_RESET; disp_val = '0; end
    endcase
  end

  for (genvar g = 0; g <= NDIG; g++) begin : g_dig
    if (g == NDIG) begin : g_letter
      hex2seg u_seg (.nibble(letter), .seg(hex_out[g*7 +: 7]));
    end else begin : g_value
      hex2seg u_seg (.nibble(disp_val[g*4 +: 4]), .seg(hex_out[g*7 +: 7]));
    end
  end

endmodule
